// File: rtl/regfile_wport_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wport_arbiter_pkg
// Description : Shared widths, register-zero constant and write-entry type.
// Revision    : 1.0
// ============================================================================
`ifndef DWORD
`define DWORD 32
`endif

package regfile_wport_arbiter_pkg;
  localparam int REG_AW  = 5;
  localparam int REG_DW  = `DWORD;
  localparam int REG_NUM = 1 << REG_AW;

  localparam logic [REG_AW-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [REG_AW-1:0] addr;
    logic [REG_DW-1:0] data;
  } wr_entry_t;
endpackage
`default_nettype wire

// File: rtl/regfile_wport_arbiter_wport_fifo.sv
`default_nettype none
// ============================================================================
// Module      : wport_fifo
// Description : Synchronous FIFO holding deferred multicycle write entries.
// Revision    : 1.0
// ============================================================================
module wport_fifo
  import regfile_wport_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push,
  input  wr_entry_t push_entry,
  input  logic      pop,
  output logic      full,
  output logic      empty,
  output wr_entry_t head
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] c_ptr_one = 1;
  localparam logic [PTR_W:0]   c_cnt_one = 1;
  localparam logic [PTR_W:0]   c_cnt_max = (PTR_W+1)'(DEPTH);

  wr_entry_t        r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign full      = (r_count == c_cnt_max);
  assign empty     = (r_count == '0);
  assign w_do_push = push & ~full;
  assign w_do_pop  = pop & ~empty;
  assign head      = r_mem[r_rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + c_ptr_one;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_one;
      if (w_do_push && !w_do_pop)      r_count <= r_count + c_cnt_one;
      else if (w_do_pop && !w_do_push) r_count <= r_count - c_cnt_one;
    end
  end

  // Storage needs no reset: occupancy is governed by the pointers.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= push_entry;
  end
endmodule
`default_nettype wire

// File: rtl/regfile_wport_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wport_arbiter
// Description : Shares the register-file write port between writeback (A)
//               and the multicycle unit (B), with scoreboard hazard output.
// Revision    : 1.0
// ============================================================================
module regfile_wport_arbiter
  import regfile_wport_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_we,
  input  logic [REG_AW-1:0] a_addr,
  input  logic [REG_DW-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [REG_AW-1:0] b_addr,
  input  logic [REG_DW-1:0] b_data,
  input  logic              sb_set,
  input  logic [REG_AW-1:0] sb_addr,
  input  logic [REG_AW-1:0] rs_addr,
  input  logic [REG_AW-1:0] rt_addr,
  output logic              hazard,
  output logic              w,
  output logic [REG_AW-1:0] w_addr_reg,
  output logic [REG_DW-1:0] w_data_reg,
  output logic [CNT_W-1:0]  defer_cnt
);
  wr_entry_t          w_head;
  wr_entry_t          w_b_entry;
  logic               w_full;
  logic               w_empty;
  logic               w_b_accept;
  logic               w_push;
  logic               w_pop;
  logic               w_sel_valid;
  logic [REG_AW-1:0]  w_sel_addr;
  logic [REG_DW-1:0]  w_sel_data;
  logic               w_b_commit;
  logic [REG_AW-1:0]  w_commit_addr;
  logic [REG_NUM-1:0] r_busy;
  logic [REG_NUM-1:0] w_busy_next;
  logic [CNT_W-1:0]   r_defer_cnt;

  assign w_b_entry  = '{addr: b_addr, data: b_data};
  assign b_ready    = ~w_full;
  assign w_b_accept = b_valid & b_ready;
  assign w_push     = w_b_accept & (a_we | ~w_empty);

  always_comb begin
    w_sel_valid   = 1'b0;
    w_sel_addr    = '0;
    w_sel_data    = '0;
    w_pop         = 1'b0;
    w_b_commit    = 1'b0;
    w_commit_addr = '0;
    if (a_we) begin
      w_sel_valid = 1'b1;
      w_sel_addr  = a_addr;
      w_sel_data  = a_data;
    end else if (!w_empty) begin
      w_sel_valid   = 1'b1;
      w_sel_addr    = w_head.addr;
      w_sel_data    = w_head.data;
      w_pop         = 1'b1;
      w_b_commit    = 1'b1;
      w_commit_addr = w_head.addr;
    end else if (w_b_accept) begin
      w_sel_valid   = 1'b1;
      w_sel_addr    = b_addr;
      w_sel_data    = b_data;
      w_b_commit    = 1'b1;
      w_commit_addr = b_addr;
    end
  end

  // r0 writes are consumed (pop / busy clear) but never reach the regfile.
  assign w          = w_sel_valid & (w_sel_addr != REG_ZERO);
  assign w_addr_reg = w_sel_addr;
  assign w_data_reg = w_sel_data;

  wport_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_wport_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (w_push),
    .push_entry (w_b_entry),
    .pop        (w_pop),
    .full       (w_full),
    .empty      (w_empty),
    .head       (w_head)
  );

  // Clear first so a same-edge issue to the same register keeps it busy.
  always_comb begin
    w_busy_next = r_busy;
    if (w_b_commit) w_busy_next[w_commit_addr] = 1'b0;
    if (sb_set && (sb_addr != REG_ZERO)) w_busy_next[sb_addr] = 1'b1;
    w_busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy      <= '0;
      r_defer_cnt <= '0;
    end else begin
      r_busy <= w_busy_next;
      if (w_push && (r_defer_cnt != '1)) r_defer_cnt <= r_defer_cnt + 1'b1;
    end
  end

  assign hazard    = r_busy[rs_addr] | r_busy[rt_addr];
  assign defer_cnt = r_defer_cnt;
endmodule
`default_nettype wire

// File: doc/regfile_wport_arbiter.md
Name: regfile_wport_arbiter

Overview:
- Shares the single write port of the 32x32 register file between two requesters.
  - Requester A: pipeline writeback. It has fixed priority and never stalls.
  - Requester B: the multicycle unit result (mult/div). It uses a valid/ready handshake.
- B results that lose arbitration are held in a small FIFO.
- A 32-bit scoreboard tracks destination registers with an outstanding multicycle result and drives the decode-stage hazard output.
- The block sits between writeback/multicycle unit and the register file's w/w_addr_reg/w_data_reg inputs.

Parameters:
- FIFO_DEPTH, 2, entries in the B deferral FIFO (power of 2, >=2)
- CNT_W, 16, width of the saturating deferral counter

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- a_we  in  1  writeback write request (A)
- a_addr  in  5  A destination register
- a_data  in  32  A write data
- b_valid  in  1  multicycle result valid (B)
- b_ready  out  1  block can accept a B result this cycle
- b_addr  in  5  B destination register
- b_data  in  32  B result data
- sb_set  in  1  multicycle op issued; mark sb_addr busy
- sb_addr  in  5  destination of issued multicycle op
- rs_addr  in  5  decode source register 1
- rt_addr  in  5  decode source register 2
- hazard  out  1  rs or rt is busy in the scoreboard (combinational)
- w  out  1  register file write enable
- w_addr_reg  out  5  register file write address
- w_data_reg  out  32  register file write data
- defer_cnt  out  CNT_W  saturating count of B transfers that were deferred

Behaviour:
- Reset (rst_n low, async):
  - FIFO empty, pointers 0.
  - All scoreboard bits 0.
  - defer_cnt = 0.
  - b_ready = 1.
  - With no inputs active, w = 0, w_addr_reg = 0, w_data_reg = 0.
- Reset mid-operation discards FIFO contents and busy bits; no write is issued for discarded entries.
- Write-port selection is combinational, in priority order:
  1. a_we = 1: port driven from A.
  2. FIFO non-empty: port driven from the FIFO head; head pops at the clock edge.
  3. b_valid & b_ready & FIFO empty: B bypasses the FIFO straight to the port.
  4. Otherwise w = 0.
- B acceptance:
  - Accepted on the edge where b_valid & b_ready.
  - b_ready = !full. Pop and push in the same cycle are allowed when full? No: b_ready is computed before the pop, so full means not ready.
  - B data must stay stable until accepted.
- B accepted while A holds the port, or while the FIFO is non-empty:
  - The entry is pushed to the FIFO.
  - defer_cnt increments, saturating at all-ones.
- B entries commit in acceptance order. The FIFO head has priority over a new bypass.
- Address 0:
  - Any selected write to r0 drives w = 0 but still counts as committed (pop/clear).
  - sb_set with sb_addr = 0 is ignored; busy[0] is always 0.
- Scoreboard:
  - busy[sb_addr] is set on an edge with sb_set.
  - busy[x] is cleared on the edge where a B write to x commits to the port (bypass or FIFO pop).
  - Set and clear of the same register on the same edge: set wins.
  - A writes never touch busy bits.
- hazard = busy[rs_addr] | busy[rt_addr], combinational.
  - A register becomes non-busy in the cycle after its B commit, so the regfile write is visible before the read.
- Latency:
  - A: 0 cycles to the port.
  - B with free port and empty FIFO: 0 cycles.
  - Each A cycle adds 1 cycle per queued entry.
- Full FIFO with continuous A writes: B is back-pressured indefinitely. No loss and no reordering.
- defer_cnt only resets on rst_n.

Decomposition:
- Shared package/defines:
  - Register address width (5) and data width (32), via the existing `DWORD define.
  - Register zero constant.
- One natural sub-module: wport_fifo.
  - Synchronous FIFO, DEPTH x (5+32).
  - Ports: push, pop, full, empty, head data.
  - Asynchronous active-low reset.
- Arbitration, scoreboard and counter stay in the top level.

Test Plan:
- Reset, then a_we = 1, a_addr = 3, a_data = 0x11 -> same cycle w = 1, w_addr_reg = 3, w_data_reg = 0x11; defer_cnt = 0.
- sb_set with sb_addr = 5, then rs_addr = 5 -> hazard = 1. Then b_valid, b_addr = 5, b_data = 0xAB with a_we = 0 -> bypass write of 0xAB to r5 that cycle; hazard = 0 next cycle.
- a_we = 1 for 4 cycles while B offers r6 = 0x1, r7 = 0x2, r8 = 0x3:
  - First two are accepted and b_ready = 0 on the third.
  - After A stops, writes go out r6, r7, then r8 on consecutive cycles.
  - defer_cnt = 3.
- sb_set on r9 on the same edge that a queued B write to r9 commits -> busy[9] remains 1; hazard on rt_addr = 9 stays 1.
- B write to r0 with value 0xFFFF_FFFF -> w = 0; FIFO/bypass consumed; b_ready unaffected. sb_set with sb_addr = 0 -> hazard stays 0.
- Assert rst_n low asynchronously with 2 entries queued -> immediately empty, b_ready = 1, hazard = 0. No writes issued after release.
